// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around mem_arbiter.
// master: the arbiter; slave: the requesters and memory around it.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_done;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [2:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_done;
  logic [DW-1:0] d_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [2:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_gnt, i_done, i_rdata, d_gnt, d_done, d_rdata,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational two-way picker; ARB_RR_EN selects round-robin, otherwise data beats fetch.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_req_i,
  input  logic       d_req_i,
`ifdef ARB_RR_EN
  input  arb_owner_e last_own_i,
`endif
  input  logic       accept_i,
  output logic       i_gnt_o,
  output logic       d_gnt_o
);

`ifdef ARB_RR_EN
  // On a tie the requester that did not own the memory last goes first.
  assign d_gnt_o = accept_i & d_req_i & (~i_req_i | (last_own_i == OWN_I));
  assign i_gnt_o = accept_i & i_req_i & (~d_req_i | (last_own_i == OWN_D));
`else
  assign d_gnt_o = accept_i & d_req_i;
  assign i_gnt_o = accept_i & i_req_i & ~d_req_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and load/store requesters.
// Define ARB_RR_EN for round-robin arbitration; fixed data-over-fetch priority otherwise.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.master bus
);

  arb_state_e    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [2:0]    mem_size_q, mem_size_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic busy;
  logic accept;
  logic i_gnt;
  logic d_gnt;

  assign busy = (state_q != IDLE);
  // Grants are forced low while reset is held, even though they are combinational.
  assign accept = ~reset & (~busy | bus.mem_ack);

`ifdef ARB_RR_EN
  arb_owner_e last_own_q, last_own_d;

  always_comb begin
    last_own_d = last_own_q;
    if (d_gnt) begin
      last_own_d = OWN_D;
    end else if (i_gnt) begin
      last_own_d = OWN_I;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_own_q <= OWN_I;
    end else begin
      last_own_q <= last_own_d;
    end
  end
`endif

  arb_pick u_pick (
    .i_req_i    (bus.i_req),
    .d_req_i    (bus.d_req),
`ifdef ARB_RR_EN
    .last_own_i (last_own_q),
`endif
    .accept_i   (accept),
    .i_gnt_o    (i_gnt),
    .d_gnt_o    (d_gnt)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;

    if (busy && bus.mem_ack) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
      if (state_q == BUSY_I) begin
        i_done_d  = 1'b1;
        i_rdata_d = bus.mem_rdata;
      end else begin
        d_done_d  = 1'b1;
        d_rdata_d = bus.mem_rdata;
      end
    end

    // A grant in the ack cycle overrides the return to IDLE, giving gapless back-to-back.
    if (d_gnt) begin
      state_d     = BUSY_D;
      mem_req_d   = 1'b1;
      mem_we_d    = bus.d_we;
      mem_size_d  = bus.d_size;
      mem_addr_d  = bus.d_addr;
      mem_wdata_d = bus.d_wdata;
    end else if (i_gnt) begin
      state_d    = BUSY_I;
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_size_d = MEM_W;
      mem_addr_d = bus.i_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.i_done    = i_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_size  = mem_size_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
